// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: fetches NUM_FIELD-word cfg entries from memory into a 2-slot prefetch
// buffer and issues them on a valid/busy cfg port. Define CFG_LOADER_PERF_EN for stall_cycles.
module cfg_stream_loader #(
  parameter int PE_ROW    = 12,
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 16,
  parameter int CWIDTH    = 64,
  parameter int NUM_FIELD = 4,
  parameter int CNTW      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [AWIDTH-1:0]           start_base,
  input  logic [CNTW-1:0]             start_count,
  output logic                        ready,
  output logic                        done,
  output logic                        mem_rreq,
  output logic [AWIDTH-1:0]           mem_addr,
  input  logic [DWIDTH*PE_ROW-1:0]    mem_rdata,
  output logic                        cfg_valid,
  input  logic                        cfg_busy,
  output logic [NUM_FIELD*CWIDTH-1:0] cfg_data,
  output logic [CNTW-1:0]             cfg_index
`ifdef CFG_LOADER_PERF_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);
  localparam int MWIDTH = DWIDTH*PE_ROW;
  localparam int FW = (NUM_FIELD > 1) ? $clog2(NUM_FIELD) : 1;
  localparam logic [FW-1:0] LAST_FLD = FW'(NUM_FIELD-1);

  typedef enum logic [1:0] {F_IDLE, F_READ, F_HOLD} fstate_t;

  fstate_t                                state_q, state_d;
  logic                                   run_q, done_q;
  logic [AWIDTH-1:0]                      addr_q;
  logic [CNTW-1:0]                        cnt_q, req_cnt, iss_cnt;
  logic [FW-1:0]                          fld_q, rd_fld_q;
  logic                                   rd_vld_q, rd_slot_q;
  logic [1:0]                             full_q;
  logic [1:0][NUM_FIELD-1:0][CWIDTH-1:0]  slot_q;

  logic accept, xfer, rd_fire, last_fld, all_req, pend_one, last_iss;

  // Entry n lives in slot n[0]: fetch side writes slot req_cnt[0], issue side reads iss_cnt[0].
  assign ready     = !run_q;
  assign done      = done_q;
  assign accept    = start && ready && !done_q;
  assign rd_fire   = (state_q == F_READ);
  assign mem_rreq  = rd_fire;
  assign mem_addr  = addr_q;
  assign cfg_valid = full_q[iss_cnt[0]];
  assign cfg_data  = slot_q[iss_cnt[0]];
  assign cfg_index = iss_cnt;
  assign xfer      = cfg_valid && !cfg_busy;
  assign last_fld  = (fld_q == LAST_FLD);
  assign all_req   = ((req_cnt + CNTW'(1)) == cnt_q);
  assign pend_one  = ((req_cnt - iss_cnt) == CNTW'(1));
  assign last_iss  = (iss_cnt == (cnt_q - CNTW'(1)));

  if (MWIDTH > CWIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^mem_rdata[MWIDTH-1:CWIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE: if (accept && (start_count != '0)) state_d = F_READ;
      F_READ: if (rd_fire && last_fld) begin
        if (all_req)                  state_d = F_IDLE;
        // the other slot is still waiting for its transfer: park until it frees
        else if (pend_one && !xfer)   state_d = F_HOLD;
      end
      F_HOLD: if (xfer) state_d = F_READ;
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= F_IDLE;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      req_cnt   <= '0;
      iss_cnt   <= '0;
      fld_q     <= '0;
      rd_fld_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_slot_q <= 1'b0;
      full_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= 1'b0;
      rd_vld_q  <= rd_fire;
      rd_fld_q  <= fld_q;
      rd_slot_q <= req_cnt[0];
      if (accept) begin
        addr_q  <= start_base;
        cnt_q   <= start_count;
        req_cnt <= '0;
        iss_cnt <= '0;
        fld_q   <= '0;
        run_q   <= (start_count != '0);
        done_q  <= (start_count == '0);
      end
      if (rd_fire) begin
        addr_q <= addr_q + AWIDTH'(1);
        fld_q  <= last_fld ? '0 : fld_q + FW'(1);
        if (last_fld) req_cnt <= req_cnt + CNTW'(1);
      end
      if (rd_vld_q && (rd_fld_q == LAST_FLD)) full_q[rd_slot_q] <= 1'b1;
      if (xfer) begin
        full_q[iss_cnt[0]] <= 1'b0;
        iss_cnt            <= iss_cnt + CNTW'(1);
        if (last_iss) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           slot_q <= '0;
    else if (rd_vld_q) slot_q[rd_slot_q][rd_fld_q] <= mem_rdata[CWIDTH-1:0];
  end

`ifdef CFG_LOADER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept)                                   stall_cycles <= '0;
    else if (cfg_valid && cfg_busy && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Randomized bench for cfg_stream_loader: memory responder, address/data scoreboard built
// from the entry layout (base + NUM_FIELD*i + k), and timing checks on latency, rate and done.
module tb_cfg_stream_loader;
  localparam int NF = 4;
  localparam int CW = 64;
  localparam int MW = 192;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   start_base;
  logic [7:0]    start_count;
  logic          ready, done, mem_rreq, cfg_valid, cfg_busy;
  logic [15:0]   mem_addr;
  logic [MW-1:0] mem_rdata = '0;
  logic [NF*CW-1:0] cfg_data;
  logic [7:0]    cfg_index;
`ifdef CFG_LOADER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  cfg_stream_loader #(.PE_ROW(12), .DWIDTH(16), .AWIDTH(16), .CWIDTH(CW), .NUM_FIELD(NF), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_base(start_base), .start_count(start_count),
    .ready(ready), .done(done), .mem_rreq(mem_rreq), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_data(cfg_data), .cfg_index(cfg_index)
`ifdef CFG_LOADER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, last_xfer_cyc = 0;
  int n_reads = 0, n_xfer = 0, m_cnt = 0;
  logic [15:0] m_base = '0, exp_addr = '0;
  logic [31:0] salt = '0;
  bit seen_v = 0, prev_stall = 0, full_rate = 0;
  logic [NF*CW-1:0] prev_data;
  logic [7:0] prev_idx;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [MW-1:0] mem_word(input logic [15:0] a);
    return {salt, salt ^ 32'h5A5A_0F0F, ~salt, salt + {16'h0, a},
            salt[31:16] ^ a, a, ~a, salt[15:0] + a};
  endfunction

  function automatic logic [NF*CW-1:0] exp_entry(input int i);
    logic [NF*CW-1:0] e;
    logic [15:0] a;
    logic [MW-1:0] w;
    e = '0;
    for (int k = 0; k < NF; k++) begin
      a = m_base + 16'(NF*i + k);
      w = mem_word(a);
      e[k*CW +: CW] = w[CW-1:0];
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem_rreq ? mem_word(mem_addr) : '0;
  end

  // Scoreboard: reads in address order, at most two entries ahead, transfers in index order.
  always @(negedge clk) begin
    if (mem_rreq === 1'b1) begin
      chk("rd_count", n_reads < m_cnt*NF, 1'b1);
      chk("rd_addr", mem_addr, exp_addr);
      chk("rd_window", (n_reads / NF) < (n_xfer + 2), 1'b1);
      exp_addr = exp_addr + 16'd1;
      n_reads++;
    end
    if (cfg_valid === 1'b1) begin
      if (!seen_v) begin
        seen_v = 1;
        chk("first_valid_lat", cyc - start_cyc, NF + 2);
      end
      if (prev_stall) begin
        chk("stall_data", cfg_data, prev_data);
        chk("stall_index", cfg_index, prev_idx);
      end
      if (cfg_busy === 1'b0) begin
        chk("xfer_expected", n_xfer < m_cnt, 1'b1);
        chk("xfer_index", cfg_index, n_xfer);
        chk("xfer_data", cfg_data, exp_entry(n_xfer));
        if (full_rate) chk("xfer_rate", cyc - start_cyc, NF + 2 + NF*n_xfer);
        n_xfer++;
        last_xfer_cyc = cyc;
      end
    end
    prev_stall = (cfg_valid === 1'b1) && (cfg_busy === 1'b1);
    prev_data  = cfg_data;
    prev_idx   = cfg_index;
  end

  task automatic setup_model(input logic [15:0] base, input int cnt);
    salt = $urandom;
    m_base = base; m_cnt = cnt; exp_addr = base;
    n_reads = 0; n_xfer = 0; seen_v = 0; prev_stall = 0;
  endtask

  task automatic run(input logic [15:0] base, input logic [7:0] cnt, input int busy_pct,
                     input bit hold, input bit restart);
    bit got_done;
    int i;
    setup_model(base, int'(cnt));
    full_rate = (busy_pct == 0) && !hold;
    cfg_busy = hold;
    start = 1'b1; start_base = base; start_count = cnt; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_low", ready, 1'b0);
    if (hold) begin
      i = 0;
      while (cfg_valid !== 1'b1 && i < 100) begin @(posedge clk); #1; i++; end
      repeat (50) begin @(posedge clk); #1; end
      chk("hold_valid", cfg_valid, 1'b1);
      chk("hold_reads", n_reads, 2*NF);
`ifdef CFG_LOADER_PERF_EN
      chk("hold_stall_cycles", stall_cycles, 32'd50);
`endif
      cfg_busy = 1'b0;
    end
    got_done = 0;
    for (int j = 0; j < 64 + 12*int'(cnt)*NF; j++) begin
      if (done === 1'b1) begin got_done = 1; break; end
      if (restart && j == 5) begin
        start = 1'b1; start_base = ~base; start_count = cnt + 8'd3;
      end else start = 1'b0;
      if (busy_pct > 0) cfg_busy = ($urandom_range(99) < busy_pct);
      @(posedge clk); #1;
    end
    start = 1'b0; cfg_busy = 1'b0;
    chk("done_seen", got_done, 1'b1);
    if (got_done) begin
      chk("xfer_total", n_xfer, int'(cnt));
      chk("ready_at_done", ready, 1'b1);
      chk("done_lat", cyc, last_xfer_cyc + 1);
`ifdef CFG_LOADER_PERF_EN
      if (hold) chk("final_stall_cycles", stall_cycles, 32'd50);
`endif
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
  endtask

  task automatic zero_count();
    setup_model(16'h1234, 0);
    start = 1'b1; start_base = 16'h1234; start_count = 8'd0;
    @(posedge clk); #1;
    chk("c0_done", done, 1'b1);
    chk("c0_ready", ready, 1'b1);
    // start during the done cycle must be dropped
    start_count = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("c0_done_pulse", done, 1'b0);
    chk("c0_start_ignored", ready, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    chk("c0_no_reads", n_reads, 0);
  endtask

  task automatic mid_reset();
    int i;
    setup_model(16'($urandom), 3);
    full_rate = 1;
    cfg_busy = 1'b0;
    start = 1'b1; start_base = m_base; start_count = 8'd3; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    while (n_reads < NF + 1 && i < 100) begin @(posedge clk); #1; i++; end
    chk("rst_mid_fetch", n_reads, NF + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0;
    chk("rst_valid", cfg_valid, 1'b0);
    chk("rst_rreq", mem_rreq, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_index", cfg_index, 8'd0);
    repeat (3) begin @(posedge clk); #1; end
    run(16'h0100, 8'd1, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_base = '0; start_count = '0; cfg_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", ready, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_rreq", mem_rreq, 1'b0);
    chk("reset_valid", cfg_valid, 1'b0);
    chk("reset_addr", mem_addr, 16'h0);
    chk("reset_data", cfg_data, '0);
    chk("reset_index", cfg_index, 8'h0);
`ifdef CFG_LOADER_PERF_EN
    chk("reset_stall", stall_cycles, 32'h0);
`endif
    @(posedge clk); #1;

    run(16'h0010, 8'd3, 0, 0, 0);
    chk("t1_reads", n_reads, 12);
    zero_count();
    run(16'hFFFE, 8'd1, 0, 0, 0);
    chk("wrap_end_addr", exp_addr, 16'h0002);
    run(16'($urandom), 8'd4, 0, 1, 0);
    mid_reset();
    run(16'($urandom), 8'd5, 30, 0, 1);
    repeat (8) run(16'($urandom), 8'($urandom_range(1, 6)), $urandom_range(0, 70), 0, 0);
    run(16'hFF80, 8'd255, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
